// File: rtl/ges_read_ctrl_if.sv
// I2C transaction bus between the gesture read controller and the
// shared I2C driver: one launch pulse out, one completion pulse back.
interface ges_read_ctrl_if;
  logic       i2c_start;
  logic       i2c_rw;
  logic [7:0] i2c_reg_addr;
  logic [7:0] i2c_wr_data;
  logic       i2c_end;
  logic [7:0] i2c_rd_data;

  modport master (
    output i2c_start,
    output i2c_rw,
    output i2c_reg_addr,
    output i2c_wr_data,
    input  i2c_end,
    input  i2c_rd_data
  );

  modport slave (
    input  i2c_start,
    input  i2c_rw,
    input  i2c_reg_addr,
    input  i2c_wr_data,
    output i2c_end,
    output i2c_rd_data
  );
endinterface

// File: rtl/ges_read_ctrl.sv
// PAJ7620 read-side controller: selects bank 0, polls flag registers
// 0x43/0x44 and turns them into a one-cycle gesture code pulse.
module ges_read_ctrl #(
  parameter logic [19:0] POLL_CNT = 20'd100_000,
  parameter logic [15:0] TIMEOUT  = 16'd5_000
) (
  input  logic             i2c_clk,
  input  logic             sys_rst_n,
  input  logic             cfg_done,
  ges_read_ctrl_if.master  bus,
  output logic             ges_valid,
  output logic [3:0]       ges_code,
  output logic             rd_timeout
);

  typedef enum logic [3:0] {
    IDLE,
    BANK,
    BANK_W,
    WAIT,
    RD43,
    RD43_W,
    RD44,
    RD44_W,
    DECODE
  } state_t;

  state_t      state;
  logic [19:0] poll_cnt;
  logic [15:0] to_cnt;
  logic        bank_ok;
  logic        wave;
  logic [7:0]  flag43;
  logic        to_hit;
  logic        poll_hit;

  assign to_hit   = (to_cnt == TIMEOUT - 16'd1);
  assign poll_hit = (poll_cnt == POLL_CNT - 20'd1);

  // Code is 1 + index of the lowest set flag bit.
  function automatic logic [3:0] lsb_code(input logic [7:0] f);
    lsb_code = 4'd0;
    for (int i = 7; i >= 0; i--)
      if (f[i]) lsb_code = 4'(i + 1);
  endfunction

  always_ff @(posedge i2c_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state            <= IDLE;
      poll_cnt         <= '0;
      to_cnt           <= '0;
      bank_ok          <= 1'b0;
      wave             <= 1'b0;
      flag43           <= '0;
      bus.i2c_start    <= 1'b0;
      bus.i2c_rw       <= 1'b0;
      bus.i2c_reg_addr <= '0;
      bus.i2c_wr_data  <= '0;
      ges_valid        <= 1'b0;
      ges_code         <= '0;
      rd_timeout       <= 1'b0;
    end else begin
      bus.i2c_start <= 1'b0;
      ges_valid     <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cfg_done) begin
            state            <= BANK;
            bus.i2c_start    <= 1'b1;
            bus.i2c_rw       <= 1'b0;
            bus.i2c_reg_addr <= 8'hEF;
            bus.i2c_wr_data  <= 8'h00;
          end
        end
        BANK: begin
          state  <= BANK_W;
          to_cnt <= '0;
        end
        RD43: begin
          state  <= RD43_W;
          to_cnt <= '0;
        end
        RD44: begin
          state  <= RD44_W;
          to_cnt <= '0;
        end
        WAIT: begin
          if (!cfg_done) begin
            state    <= IDLE;
            bank_ok  <= 1'b0;
            poll_cnt <= '0;
          end else if (poll_hit) begin
            poll_cnt      <= '0;
            bus.i2c_start <= 1'b1;
            if (bank_ok) begin
              state            <= RD43;
              bus.i2c_rw       <= 1'b1;
              bus.i2c_reg_addr <= 8'h43;
            end else begin
              state            <= BANK;
              bus.i2c_rw       <= 1'b0;
              bus.i2c_reg_addr <= 8'hEF;
              bus.i2c_wr_data  <= 8'h00;
            end
          end else begin
            poll_cnt <= poll_cnt + 20'd1;
          end
        end
        BANK_W, RD43_W, RD44_W: begin
          // A completion on the last allowed cycle still counts as success.
          if (bus.i2c_end) begin
            if (state == BANK_W) begin
              bank_ok <= 1'b1;
              state   <= WAIT;
            end else if (state == RD43_W) begin
              flag43           <= bus.i2c_rd_data;
              state            <= RD44;
              bus.i2c_start    <= 1'b1;
              bus.i2c_rw       <= 1'b1;
              bus.i2c_reg_addr <= 8'h44;
            end else begin
              wave       <= bus.i2c_rd_data[0];
              rd_timeout <= 1'b0;
              state      <= DECODE;
            end
          end else if (to_hit) begin
            rd_timeout <= 1'b1;
            bank_ok    <= 1'b0;
            state      <= WAIT;
          end else begin
            to_cnt <= to_cnt + 16'd1;
          end
        end
        DECODE: begin
          state <= WAIT;
          if (flag43 != 8'h00) begin
            ges_valid <= 1'b1;
            ges_code  <= lsb_code(flag43);
          end else if (wave) begin
            ges_valid <= 1'b1;
            ges_code  <= 4'd9;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ges_read_ctrl.sv
// Directed bench for ges_read_ctrl with a fixed-latency I2C driver model.
module tb_ges_read_ctrl;
  localparam int POLL = 10;
  localparam int TO   = 30;
  localparam int DLY  = 20;

  logic       clk = 1'b0;
  logic       sys_rst_n;
  logic       cfg_done;
  logic       ges_valid;
  logic [3:0] ges_code;
  logic       rd_timeout;

  logic [7:0] rsp43;
  logic [7:0] rsp44;
  logic       hang43;

  int errors = 0;
  int checks = 0;

  ges_read_ctrl_if bus ();

  ges_read_ctrl #(
    .POLL_CNT (20'(POLL)),
    .TIMEOUT  (16'(TO))
  ) dut (
    .i2c_clk    (clk),
    .sys_rst_n  (sys_rst_n),
    .cfg_done   (cfg_done),
    .bus        (bus),
    .ges_valid  (ges_valid),
    .ges_code   (ges_code),
    .rd_timeout (rd_timeout)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic ev(input int sel);
    case (sel)
      0:       return bus.i2c_start;
      1:       return ges_valid;
      default: return rd_timeout;
    endcase
  endfunction

  // Counts negedges until the event is seen (bounded).
  task automatic wait_ev(input int sel, output int cyc);
    cyc = 0;
    @(negedge clk);
    cyc++;
    while (!ev(sel) && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    chk($sformatf("event%0d_seen", sel), 32'(ev(sel)), 32'd1);
  endtask

  task automatic window(input int n, output int ns, output int nv);
    ns = 0;
    nv = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bus.i2c_start) ns++;
      if (ges_valid) nv++;
    end
  endtask

  // Driver model: answers each launch DLY cycles later unless hung or reset.
  initial begin
    logic [7:0] a;
    logic       skip;
    bus.i2c_end     = 1'b0;
    bus.i2c_rd_data = 8'h00;
    forever begin
      @(posedge clk);
      if (bus.i2c_start && sys_rst_n) begin
        a    = bus.i2c_reg_addr;
        skip = hang43 && (a == 8'h43);
        for (int i = 0; i < DLY; i++) begin
          @(posedge clk);
          if (!sys_rst_n) skip = 1'b1;
        end
        if (!skip) begin
          #1;
          bus.i2c_end     = 1'b1;
          bus.i2c_rd_data = (a == 8'h43) ? rsp43 : rsp44;
          @(posedge clk);
          #1;
          bus.i2c_end     = 1'b0;
          bus.i2c_rd_data = 8'h00;
        end
      end
    end
  end

  initial begin
    int c;
    int ns;
    int nv;
    sys_rst_n = 1'b0;
    cfg_done  = 1'b0;
    rsp43     = 8'h04;
    rsp44     = 8'h00;
    hang43    = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_start", 32'(bus.i2c_start), 32'd0);
    chk("rst_rw", 32'(bus.i2c_rw), 32'd0);
    chk("rst_addr", 32'(bus.i2c_reg_addr), 32'd0);
    chk("rst_wdata", 32'(bus.i2c_wr_data), 32'd0);
    chk("rst_valid", 32'(ges_valid), 32'd0);
    chk("rst_code", 32'(ges_code), 32'd0);
    chk("rst_tmo", 32'(rd_timeout), 32'd0);
    sys_rst_n = 1'b1;
    @(negedge clk);
    chk("idle_no_start", 32'(bus.i2c_start), 32'd0);

    // Bank write, then two reads, then the decoded pulse.
    cfg_done = 1'b1;
    wait_ev(0, c);
    chk("bank_lat", 32'(c), 32'd1);
    chk("bank_rw", 32'(bus.i2c_rw), 32'd0);
    chk("bank_addr", 32'(bus.i2c_reg_addr), 32'hEF);
    chk("bank_wdata", 32'(bus.i2c_wr_data), 32'h00);
    @(negedge clk);
    chk("bank_start_1cyc", 32'(bus.i2c_start), 32'd0);
    chk("bank_addr_hold", 32'(bus.i2c_reg_addr), 32'hEF);
    wait_ev(0, c);
    chk("rd43_gap", 32'(c), 32'(1 + DLY + 1 + POLL - 1));
    chk("rd43_rw", 32'(bus.i2c_rw), 32'd1);
    chk("rd43_addr", 32'(bus.i2c_reg_addr), 32'h43);
    wait_ev(0, c);
    chk("rd44_gap", 32'(c), 32'(DLY + 2));
    chk("rd44_addr", 32'(bus.i2c_reg_addr), 32'h44);
    wait_ev(1, c);
    chk("valid_gap", 32'(c), 32'(DLY + 3));
    chk("code_left", 32'(ges_code), 32'd3);
    rsp43 = 8'h0A;
    @(negedge clk);
    chk("valid_1cyc", 32'(ges_valid), 32'd0);
    chk("code_hold", 32'(ges_code), 32'd3);

    // Lowest set bit wins; wave; nothing.
    wait_ev(1, c);
    chk("code_down", 32'(ges_code), 32'd2);
    rsp43 = 8'h00;
    rsp44 = 8'h01;
    wait_ev(1, c);
    chk("code_wave", 32'(ges_code), 32'd9);
    rsp44 = 8'h00;
    wait_ev(0, c);
    chk("none_rd43", 32'(bus.i2c_reg_addr), 32'h43);
    wait_ev(0, c);
    chk("none_rd44", 32'(bus.i2c_reg_addr), 32'h44);
    window(30, ns, nv);
    chk("none_no_valid", 32'(nv), 32'd0);
    chk("none_code_held", 32'(ges_code), 32'd9);

    // Hung RD43: timeout, then bank re-write, flag clears on good RD44.
    hang43 = 1'b1;
    wait_ev(0, c);
    chk("hang_addr", 32'(bus.i2c_reg_addr), 32'h43);
    wait_ev(2, c);
    chk("tmo_lat", 32'(c), 32'(TO + 1));
    hang43 = 1'b0;
    rsp43  = 8'h01;
    wait_ev(0, c);
    chk("tmo_rebank_gap", 32'(c), 32'(POLL));
    chk("tmo_rebank_addr", 32'(bus.i2c_reg_addr), 32'hEF);
    chk("tmo_rebank_rw", 32'(bus.i2c_rw), 32'd0);
    wait_ev(0, c);
    wait_ev(0, c);
    chk("tmo_still_set", 32'(rd_timeout), 32'd1);
    wait_ev(1, c);
    chk("tmo_cleared", 32'(rd_timeout), 32'd0);
    chk("code_up", 32'(ges_code), 32'd1);

    // cfg_done drop in WAIT, then during RD43_W.
    cfg_done = 1'b0;
    window(40, ns, nv);
    chk("cfg_drop_no_start", 32'(ns), 32'd0);
    cfg_done = 1'b1;
    wait_ev(0, c);
    chk("cfg_rebank_addr", 32'(bus.i2c_reg_addr), 32'hEF);
    rsp43 = 8'h80;
    wait_ev(0, c);
    chk("late_rd43", 32'(bus.i2c_reg_addr), 32'h43);
    repeat (2) @(negedge clk);
    cfg_done = 1'b0;
    wait_ev(0, c);
    chk("late_rd44", 32'(bus.i2c_reg_addr), 32'h44);
    wait_ev(1, c);
    chk("code_ccw", 32'(ges_code), 32'd8);
    window(40, ns, nv);
    chk("late_idle_no_start", 32'(ns), 32'd0);

    // Reset in RD44_W.
    cfg_done = 1'b1;
    wait_ev(0, c);
    wait_ev(0, c);
    wait_ev(0, c);
    chk("pre_rst_rd44", 32'(bus.i2c_reg_addr), 32'h44);
    repeat (5) @(negedge clk);
    sys_rst_n = 1'b0;
    cfg_done  = 1'b0;
    #1;
    chk("arst_addr", 32'(bus.i2c_reg_addr), 32'd0);
    chk("arst_rw", 32'(bus.i2c_rw), 32'd0);
    chk("arst_code", 32'(ges_code), 32'd0);
    chk("arst_start", 32'(bus.i2c_start), 32'd0);
    repeat (30) @(negedge clk);
    sys_rst_n = 1'b1;
    window(3, ns, nv);
    chk("post_rst_no_start", 32'(ns), 32'd0);
    cfg_done = 1'b1;
    wait_ev(0, c);
    chk("restart_addr", 32'(bus.i2c_reg_addr), 32'hEF);
    chk("restart_rw", 32'(bus.i2c_rw), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
